// File: rtl/i2s_rx_slave_if.sv
// I2S receive bus: external SCLK/LRCLK/SDATA toward the receiver, decoded
// stereo samples and status back to the consumer.
interface i2s_rx_slave_if #(
  parameter int DATA_BIT = 24
);
  logic                i_sclk;
  logic                i_lrclk;
  logic                i_sdata;
  logic [DATA_BIT-1:0] o_left;
  logic [DATA_BIT-1:0] o_right;
  logic                o_valid;
  logic                o_locked;
  logic                o_frame_err;

  modport slave (
    input  i_sclk, i_lrclk, i_sdata,
    output o_left, o_right, o_valid, o_locked, o_frame_err
  );

  modport master (
    output i_sclk, i_lrclk, i_sdata,
    input  o_left, o_right, o_valid, o_locked, o_frame_err
  );
endinterface

// File: rtl/i2s_rx_slave.sv
// I2S slave receiver: oversamples an external SCLK/LRCLK/SDATA bus in the
// 12.288 MHz domain, locks onto the frame and emits left/right word pairs.
module i2s_rx_slave #(
  parameter int DATA_BIT    = 24,
  parameter int SLOT_BIT    = 32,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic         i_clk_12_288,
  input  logic         i_reset_n,
  i2s_rx_slave_if.slave bus
);

  localparam int CNT_W = $clog2(SLOT_BIT + 2);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_BIT);
  localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(DATA_BIT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Identical synchronizer depth on all three lines keeps data aligned with the detected edge.
  logic [2:0] sclk_sync;
  logic [1:0] lrclk_sync;
  logic [1:0] sdata_sync;
  logic       edge_q;
  logic       lr_q;
  logic       sd_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sclk_sync  <= '0;
      lrclk_sync <= '0;
      sdata_sync <= '0;
      edge_q     <= 1'b0;
      lr_q       <= 1'b0;
      sd_q       <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[1:0], bus.i_sclk};
      lrclk_sync <= {lrclk_sync[0], bus.i_lrclk};
      sdata_sync <= {sdata_sync[0], bus.i_sdata};
      edge_q     <= sclk_sync[1] & ~sclk_sync[2];
      lr_q       <= lrclk_sync[1];
      sd_q       <= sdata_sync[1];
    end
  end

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [TMR_W-1:0]    timer;
  logic                lr_prev;
  logic [DATA_BIT-1:0] shift_reg;
  logic [DATA_BIT-1:0] left_hold;

  logic                lr_change;
  logic [CNT_W-1:0]    cnt_next;
  logic [DATA_BIT-1:0] shift_next;

  assign lr_change  = lr_q ^ lr_prev;
  assign cnt_next   = cnt + CNT_ONE;
  assign shift_next = {shift_reg[DATA_BIT-2:0], sd_q};

  always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state           <= HUNT;
      cnt             <= '0;
      timer           <= '0;
      lr_prev         <= 1'b0;
      // NOTE: sample registers are plain flops, cleared so post-reset outputs are deterministic.
      shift_reg       <= '0;
      left_hold       <= '0;
      bus.o_left      <= '0;
      bus.o_right     <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_locked    <= 1'b0;
      bus.o_frame_err <= 1'b0;
    end else begin
      bus.o_valid     <= 1'b0;
      bus.o_frame_err <= 1'b0;
      if (edge_q) lr_prev <= lr_q;

      case (state)
        HUNT: begin
          timer <= '0;
          if (edge_q && lr_prev && !lr_q) begin
            state <= SYNC;
            cnt   <= CNT_ONE;
          end
        end

        SYNC, LOCKED: begin
          if (edge_q) begin
            timer <= '0;
            if (lr_change) begin
              cnt <= CNT_ONE;
              if (cnt != CNT_SLOT) begin
                bus.o_frame_err <= (state == LOCKED);
                bus.o_locked    <= 1'b0;
                // A failing 1->0 edge is still a valid frame start, so hunting ends on it.
                state           <= lr_q ? HUNT : SYNC;
              end else if (!lr_q) begin
                state        <= LOCKED;
                bus.o_locked <= 1'b1;
              end
            end else if (cnt == CNT_SLOT) begin
              bus.o_frame_err <= (state == LOCKED);
              bus.o_locked    <= 1'b0;
              state           <= HUNT;
            end else begin
              cnt <= cnt_next;
              if (cnt_next <= CNT_WORD) shift_reg <= shift_next;
              if (cnt_next == CNT_WORD) begin
                if (!lr_q) begin
                  left_hold <= shift_next;
                end else if (state == LOCKED) begin
                  bus.o_left  <= left_hold;
                  bus.o_right <= shift_next;
                  bus.o_valid <= 1'b1;
                end
              end
            end
          end else if (timer == TMR_LAST) begin
            timer           <= '0;
            bus.o_frame_err <= (state == LOCKED);
            bus.o_locked    <= 1'b0;
            state           <= HUNT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state        <= HUNT;
          bus.o_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_rx_slave.sv
// Directed bench for i2s_rx_slave: frame table for lock/alignment plus
// hand-written short-slot, long-slot, SCLK-stop and mid-frame reset sequences.
module tb_i2s_rx_slave;

  localparam int DATA_BIT    = 24;
  localparam int SLOT_BIT    = 32;
  localparam int TIMEOUT_CYC = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2s_rx_slave_if #(.DATA_BIT(DATA_BIT)) bus ();

  i2s_rx_slave #(
    .DATA_BIT   (DATA_BIT),
    .SLOT_BIT   (SLOT_BIT),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .i_clk_12_288(clk),
    .i_reset_n   (rst_n),
    .bus         (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: every output pulse is logged with the cycle it was seen in.
  int          n_valid   = 0;
  int          n_ferr    = 0;
  int          n_overlap = 0;
  int          n_wide    = 0;
  int          valid_cyc = -1;
  int          ferr_cyc  = -1;
  int          lock_cyc  = -1;
  logic [23:0] cap_left  = '0;
  logic [23:0] cap_right = '0;
  logic        valid_d   = 1'b0;
  logic        err_d     = 1'b0;
  logic        locked_d  = 1'b0;

  always @(negedge clk) begin
    valid_d  <= bus.o_valid;
    err_d    <= bus.o_frame_err;
    locked_d <= bus.o_locked;
    if (bus.o_valid) begin
      n_valid   <= n_valid + 1;
      valid_cyc <= cyc;
      cap_left  <= bus.o_left;
      cap_right <= bus.o_right;
    end
    if (bus.o_frame_err) begin
      n_ferr   <= n_ferr + 1;
      ferr_cyc <= cyc;
    end
    if (bus.o_locked && !locked_d) lock_cyc <= cyc;
    if (bus.o_valid && bus.o_frame_err) n_overlap <= n_overlap + 1;
    if ((bus.o_valid && valid_d) || (bus.o_frame_err && err_d)) n_wide <= n_wide + 1;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Cycle stamps of the SCLK rising edges of interest, taken when each rise is driven.
  int last_rise_cyc  = 0;
  int slot_start_cyc = 0;
  int slot_end_cyc   = 0;
  int word_rise_cyc  = 0;
  int frame_start_cyc = 0;
  int left_end_cyc   = 0;

  // One SCLK period of 4 clk: fall (with new LRCLK/SDATA), 2 clk low, rise, 2 clk high.
  task automatic sclk_period(input logic lr, input logic d);
    @(negedge clk);
    bus.i_sclk  = 1'b0;
    bus.i_lrclk = lr;
    bus.i_sdata = d;
    @(negedge clk);
    @(negedge clk);
    bus.i_sclk    = 1'b1;
    last_rise_cyc = cyc;
    @(negedge clk);
  endtask

  // Period 0 carries the previous slot's trailing bit, periods 1..DATA_BIT the word MSB first.
  task automatic send_slot(input logic lr, input logic [23:0] word, input int len, input logic pad);
    logic d;
    for (int j = 0; j < len; j++) begin
      if (j >= 1 && j <= DATA_BIT) d = word[DATA_BIT-j];
      else                         d = pad;
      sclk_period(lr, d);
      if (j == 0)        slot_start_cyc = last_rise_cyc;
      if (j == DATA_BIT) word_rise_cyc  = last_rise_cyc;
    end
    slot_end_cyc = last_rise_cyc;
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                            input int llen, input int rlen, input logic pad);
    send_slot(1'b0, l, llen, pad);
    frame_start_cyc = slot_start_cyc;
    left_end_cyc    = slot_end_cyc;
    send_slot(1'b1, r, rlen, pad);
  endtask

  task automatic check_frame_out(input string name, input logic [23:0] l, input logic [23:0] r);
    check({name, "_left"}, 64'(cap_left), 64'(l));
    check({name, "_right"}, 64'(cap_right), 64'(r));
    check({name, "_valid_latency"}, 64'(valid_cyc), 64'(word_rise_cyc + 4));
  endtask

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        pad;
    int          exp_dvalid;
    logic        exp_locked;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
  } vec_t;

  vec_t tbl[7];
  int   nv;
  int   ne;
  int   lock_frame_start;
  int   stop_rise;

  initial begin
    tbl[0] = '{24'hA5A5A5, 24'h5A5A5A, 1'b0, 0, 1'b0, 24'h000000, 24'h000000};
    tbl[1] = '{24'hA5A5A5, 24'h5A5A5A, 1'b0, 1, 1'b1, 24'hA5A5A5, 24'h5A5A5A};
    tbl[2] = '{24'h800000, 24'h000001, 1'b1, 1, 1'b1, 24'h800000, 24'h000001};
    tbl[3] = '{24'h7FFFFF, 24'hFFFFFE, 1'b1, 1, 1'b1, 24'h7FFFFF, 24'hFFFFFE};
    tbl[4] = '{24'h800000, 24'h000001, 1'b1, 1, 1'b1, 24'h800000, 24'h000001};
    tbl[5] = '{24'h7FFFFF, 24'hFFFFFE, 1'b1, 1, 1'b1, 24'h7FFFFF, 24'hFFFFFE};
    tbl[6] = '{24'h123456, 24'hABCDEF, 1'b0, 1, 1'b1, 24'h123456, 24'hABCDEF};

    bus.i_sclk  = 1'b0;
    bus.i_lrclk = 1'b0;
    bus.i_sdata = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("reset_left",   64'(bus.o_left),      64'd0);
    check("reset_right",  64'(bus.o_right),     64'd0);
    check("reset_valid",  64'(bus.o_valid),     64'd0);
    check("reset_locked", 64'(bus.o_locked),    64'd0);
    check("reset_err",    64'(bus.o_frame_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Right-slot tail so the first table frame opens with a 1->0 transition.
    send_slot(1'b1, 24'h000000, 4, 1'b0);
    lock_frame_start = 0;
    for (int i = 0; i < 7; i++) begin
      nv = n_valid;
      send_frame(tbl[i].l, tbl[i].r, SLOT_BIT, SLOT_BIT, tbl[i].pad);
      if (i == 1) lock_frame_start = frame_start_cyc;
      #1;
      check($sformatf("vec%0d_valid_count", i), 64'(n_valid - nv), 64'(tbl[i].exp_dvalid));
      check($sformatf("vec%0d_locked", i), 64'(bus.o_locked), 64'(tbl[i].exp_locked));
      if (tbl[i].exp_dvalid != 0)
        check_frame_out($sformatf("vec%0d", i), tbl[i].exp_l, tbl[i].exp_r);
    end
    check("lock_latency", 64'(lock_cyc), 64'(lock_frame_start + 4));
    check("no_err_nominal", 64'(n_ferr), 64'd0);

    // Short right slot: error surfaces at the next 1->0, relock one frame later.
    send_frame(24'h111111, 24'h222222, SLOT_BIT, SLOT_BIT - 1, 1'b0);
    ne = n_ferr;
    nv = n_valid;
    send_frame(24'h333333, 24'h444444, SLOT_BIT, SLOT_BIT, 1'b0);
    #1;
    check("short_err_count",   64'(n_ferr - ne),  64'd1);
    check("short_err_latency", 64'(ferr_cyc),     64'(frame_start_cyc + 4));
    check("short_unlocked",    64'(bus.o_locked), 64'd0);
    check("short_no_valid",    64'(n_valid - nv), 64'd0);
    nv = n_valid;
    send_frame(24'h555555, 24'h666666, SLOT_BIT, SLOT_BIT, 1'b1);
    #1;
    check("short_relock_latency", 64'(lock_cyc),     64'(frame_start_cyc + 4));
    check("short_relock_valid",   64'(n_valid - nv), 64'd1);
    check_frame_out("short_relock", 24'h555555, 24'h666666);

    // Long left slot: overflow on the 33rd edge.
    ne = n_ferr;
    nv = n_valid;
    send_frame(24'h0F0F0F, 24'hF0F0F0, SLOT_BIT + 1, SLOT_BIT, 1'b0);
    #1;
    check("long_err_count",   64'(n_ferr - ne),  64'd1);
    check("long_err_latency", 64'(ferr_cyc),     64'(left_end_cyc + 4));
    check("long_unlocked",    64'(bus.o_locked), 64'd0);
    check("long_no_valid",    64'(n_valid - nv), 64'd0);
    send_frame(24'h0A0B0C, 24'h0D0E0F, SLOT_BIT, SLOT_BIT, 1'b0);
    #1;
    check("long_sync_unlocked", 64'(bus.o_locked), 64'd0);
    nv = n_valid;
    send_frame(24'hC0FFEE, 24'hBADCAB, SLOT_BIT, SLOT_BIT, 1'b0);
    #1;
    check("long_relock",       64'(bus.o_locked), 64'd1);
    check("long_relock_valid", 64'(n_valid - nv), 64'd1);
    check_frame_out("long_relock", 24'hC0FFEE, 24'hBADCAB);

    // SCLK stops mid left slot while locked.
    ne = n_ferr;
    send_slot(1'b0, 24'h246813, 10, 1'b0);
    stop_rise = slot_end_cyc;
    @(negedge clk);
    bus.i_sclk = 1'b0;
    repeat (TIMEOUT_CYC + 20) @(negedge clk);
    #1;
    check("stop_err_count",   64'(n_ferr - ne),  64'd1);
    check("stop_err_latency", 64'(ferr_cyc),     64'(stop_rise + 4 + TIMEOUT_CYC));
    check("stop_unlocked",    64'(bus.o_locked), 64'd0);
    send_frame(24'h111000, 24'h000111, SLOT_BIT, SLOT_BIT, 1'b0);
    send_frame(24'h222000, 24'h000222, SLOT_BIT, SLOT_BIT, 1'b0);
    nv = n_valid;
    send_frame(24'h333000, 24'h000333, SLOT_BIT, SLOT_BIT, 1'b0);
    #1;
    check("restart_locked", 64'(bus.o_locked), 64'd1);
    check("restart_valid",  64'(n_valid - nv), 64'd1);
    check_frame_out("restart", 24'h333000, 24'h000333);

    // Reset mid right slot, then resume in the middle of a right slot.
    send_slot(1'b0, 24'h987654, SLOT_BIT, 1'b0);
    send_slot(1'b1, 24'h456789, 12, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_left",   64'(bus.o_left),      64'd0);
    check("midrst_right",  64'(bus.o_right),     64'd0);
    check("midrst_locked", 64'(bus.o_locked),    64'd0);
    check("midrst_valid",  64'(bus.o_valid),     64'd0);
    check("midrst_err",    64'(bus.o_frame_err), 64'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    nv = n_valid;
    send_slot(1'b1, 24'h000000, 20, 1'b0);
    send_frame(24'hAAAAAA, 24'h555555, SLOT_BIT, SLOT_BIT, 1'b0);
    #1;
    check("late_no_valid", 64'(n_valid - nv), 64'd0);
    check("late_unlocked", 64'(bus.o_locked), 64'd0);
    send_frame(24'hFEDCBA, 24'h013579, SLOT_BIT, SLOT_BIT, 1'b0);
    #1;
    check("late_locked", 64'(bus.o_locked), 64'd1);
    check("late_valid",  64'(n_valid - nv), 64'd1);
    check_frame_out("late", 24'hFEDCBA, 24'h013579);

    check("valid_err_exclusive", 64'(n_overlap), 64'd0);
    check("pulse_width_one",     64'(n_wide),    64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
